// File: rtl/updown_counter_fsm_if.sv
// Button-side request bundle and counter/status return for updown_counter_fsm.
// The master drives U/D/load requests; the slave (counter) drives count and flags.
interface updown_counter_fsm_if #(
    parameter int WIDTH = 8
);
    logic             u;
    logic             d;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             wrapped;
    logic             busy;

    modport master (
        output u, d, ld, ld_val,
        input  count, at_max, at_min, wrapped, busy
    );

    modport slave (
        input  u, d, ld, ld_val,
        output count, at_max, at_min, wrapped, busy
    );
endinterface

// File: rtl/updown_counter_fsm.sv
// Up/down counter with edge-detected U/D, parallel load, saturate/wrap and hold-to-auto-repeat.
// A request sampled at edge k updates count after edge k+1; no backpressure, busy flags non-IDLE states.
module updown_counter_fsm #(
    parameter int WIDTH       = 8,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 255,
    parameter int STEP        = 1,
    parameter int WRAP        = 0,
    parameter int REPEAT_DLY  = 16,
    parameter int REPEAT_RATE = 4
) (
    input  logic                clk,
    input  logic                rst,
    updown_counter_fsm_if.slave bus
);
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [RW-1:0]    DLY_R  = RW'(REPEAT_DLY);
    localparam logic [RW-1:0]    RATE_R = RW'(REPEAT_RATE);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_STEP_UP,
        S_STEP_DN,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic [RW-1:0]    rpt_q, rpt_d;
    logic             first_q, first_d;
    logic             dir_up_q, dir_up_d;
    logic             u_prev_q, d_prev_q;

    logic [WIDTH:0]   cnt_x, sum_x;
    logic [WIDTH-1:0] up_val, dn_val, ld_clamp;
    logic             up_wrap, dn_wrap;
    logic             u_rise, d_rise, released;
    logic [RW-1:0]    rpt_inc, rpt_thr;

    // Step arithmetic in WIDTH+1 bits so neither overflow nor underflow can leak into count.
    always_comb begin
        cnt_x   = {1'b0, count_q};
        sum_x   = cnt_x + STEP_X;
        up_val  = sum_x[WIDTH-1:0];
        up_wrap = 1'b0;
        if (sum_x > MAX_X) begin
            if (WRAP != 0) begin
                up_val  = WIDTH'(MIN_X + (sum_x - MAX_X - 1'b1));
                up_wrap = 1'b1;
            end else begin
                up_val  = MAX_W;
            end
        end
        dn_val  = WIDTH'(cnt_x - STEP_X);
        dn_wrap = 1'b0;
        if (cnt_x < MIN_X + STEP_X) begin
            if (WRAP != 0) begin
                dn_val  = WIDTH'(MAX_X - (MIN_X + STEP_X - cnt_x - 1'b1));
                dn_wrap = 1'b1;
            end else begin
                dn_val  = MIN_W;
            end
        end
        if (bus.ld_val < MIN_W) begin
            ld_clamp = MIN_W;
        end else if (bus.ld_val > MAX_W) begin
            ld_clamp = MAX_W;
        end else begin
            ld_clamp = bus.ld_val;
        end
    end

    assign u_rise   = bus.u & ~u_prev_q;
    assign d_rise   = bus.d & ~d_prev_q;
    assign released = dir_up_q ? (~bus.u | bus.d) : (~bus.d | bus.u);
    assign rpt_inc  = rpt_q + 1'b1;
    assign rpt_thr  = first_q ? RATE_R : DLY_R;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wrapped_d = 1'b0;
        rpt_d     = rpt_q;
        first_d   = first_q;
        dir_up_d  = dir_up_q;
        case (state_q)
            S_INIT: begin
                count_d = MIN_W;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.ld) begin
                    state_d = S_LOAD;
                end else if (u_rise && !bus.d) begin
                    state_d = S_STEP_UP;
                end else if (d_rise && !bus.u) begin
                    state_d = S_STEP_DN;
                end
            end
            S_LOAD: begin
                count_d = ld_clamp;
                state_d = S_IDLE;
            end
            S_STEP_UP: begin
                count_d   = up_val;
                wrapped_d = up_wrap;
                dir_up_d  = 1'b1;
                rpt_d     = '0;
                state_d   = S_HOLD;
            end
            S_STEP_DN: begin
                count_d   = dn_val;
                wrapped_d = dn_wrap;
                dir_up_d  = 1'b0;
                rpt_d     = '0;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (released) begin
                    state_d = S_IDLE;
                    rpt_d   = '0;
                    first_d = 1'b0;
                end else if (bus.ld) begin
                    state_d = S_LOAD;
                    rpt_d   = '0;
                    first_d = 1'b0;
                end else if (REPEAT_DLY != 0) begin
                    if (rpt_inc == rpt_thr) begin
                        state_d = dir_up_q ? S_STEP_UP : S_STEP_DN;
                        rpt_d   = '0;
                        first_d = 1'b1;
                    end else begin
                        rpt_d   = rpt_inc;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            count_q   <= MIN_W;
            wrapped_q <= 1'b0;
            rpt_q     <= '0;
            first_q   <= 1'b0;
            dir_up_q  <= 1'b0;
            u_prev_q  <= 1'b0;
            d_prev_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            rpt_q     <= rpt_d;
            first_q   <= first_d;
            dir_up_q  <= dir_up_d;
            u_prev_q  <= bus.u;
            d_prev_q  <= bus.d;
        end
    end

    assign bus.count   = count_q;
    assign bus.at_max  = (count_q == MAX_W);
    assign bus.at_min  = (count_q == MIN_W);
    assign bus.wrapped = wrapped_q;
    assign bus.busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_updown_counter_fsm.sv
// Two counters (saturating and wrapping, different repeat timings) driven by the same stimulus.
// Expected count-change events are queued per instance and matched by an independent monitor.
module tb_updown_counter_fsm;
    localparam int W     = 8;
    localparam int MINV  = 2;
    localparam int MAXV  = 9;
    localparam int STP   = 3;
    localparam int DLY0  = 5;
    localparam int RATE0 = 3;
    localparam int DLY1  = 16;
    localparam int RATE1 = 4;

    typedef struct {
        int cyc;
        int cnt;
        bit wr;
    } ev_t;

    logic         clk;
    logic         rst;
    logic         u_s, d_s, ld_s;
    logic [W-1:0] ldv_s;
    int           cyc;
    int           checks;
    int           errors;
    bit           mon_en;
    int           mc[2];
    int           prev_cnt[2];
    ev_t          q0[$];
    ev_t          q1[$];

    updown_counter_fsm_if #(.WIDTH(W)) bus0 ();
    updown_counter_fsm_if #(.WIDTH(W)) bus1 ();

    assign bus0.u = u_s;   assign bus0.d = d_s;   assign bus0.ld = ld_s;   assign bus0.ld_val = ldv_s;
    assign bus1.u = u_s;   assign bus1.d = d_s;   assign bus1.ld = ld_s;   assign bus1.ld_val = ldv_s;

    logic [W-1:0] obs_cnt[2];
    logic         obs_wr[2], obs_max[2], obs_min[2], obs_busy[2];
    assign obs_cnt[0] = bus0.count;   assign obs_cnt[1] = bus1.count;
    assign obs_wr[0]  = bus0.wrapped; assign obs_wr[1]  = bus1.wrapped;
    assign obs_max[0] = bus0.at_max;  assign obs_max[1] = bus1.at_max;
    assign obs_min[0] = bus0.at_min;  assign obs_min[1] = bus1.at_min;
    assign obs_busy[0] = bus0.busy;   assign obs_busy[1] = bus1.busy;

    updown_counter_fsm #(
        .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .STEP(STP), .WRAP(0),
        .REPEAT_DLY(DLY0), .REPEAT_RATE(RATE0)
    ) dut_sat (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    updown_counter_fsm #(
        .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .STEP(STP), .WRAP(1),
        .REPEAT_DLY(DLY1), .REPEAT_RATE(RATE1)
    ) dut_wrap (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dly(int k);
        return (k == 0) ? DLY0 : DLY1;
    endfunction

    function automatic int rate(int k);
        return (k == 0) ? RATE0 : RATE1;
    endfunction

    function automatic bit wrp(int k);
        return k == 1;
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t qpop(int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // An event exists only when the visible count changes or a wrap pulse is due.
    function automatic void push_ev(int k, int e, int nv, bit w);
        ev_t ev;
        ev.cyc = e;
        ev.cnt = nv;
        ev.wr  = w;
        if (nv != mc[k] || w) begin
            if (k == 0) q0.push_back(ev);
            else        q1.push_back(ev);
        end
        mc[k] = nv;
    endfunction

    function automatic void do_step(int k, bit up, int e);
        int v;
        int nv;
        bit w;
        v = mc[k];
        w = 1'b0;
        if (up) begin
            nv = v + STP;
            if (nv > MAXV) begin
                if (wrp(k)) begin
                    nv = MINV + (nv - MAXV - 1);
                    w  = 1'b1;
                end else begin
                    nv = MAXV;
                end
            end
        end else begin
            if (v < MINV + STP) begin
                if (wrp(k)) begin
                    nv = MAXV - (MINV + STP - v - 1);
                    w  = 1'b1;
                end else begin
                    nv = MINV;
                end
            end else begin
                nv = v - STP;
            end
        end
        push_ev(k, e, nv, w);
    endfunction

    function automatic void do_load(int k, int e, int v);
        push_ev(k, e, (v < MINV) ? MINV : ((v > MAXV) ? MAXV : v), 1'b0);
    endfunction

    // A press first sampled at edge t and held h edges: one step at t+1, then repeats
    // DLY+1 edges later and every RATE+1 edges while the press still covers the decision edge.
    function automatic void model_press(int k, bit up, int t, int h);
        int e;
        e = t + 1;
        do_step(k, up, e);
        if (dly(k) == 0) return;
        e = e + dly(k) + 1;
        while (e <= t + h) begin
            do_step(k, up, e);
            e = e + rate(k) + 1;
        end
    endfunction

    task automatic chk(bit ok, string name, int k, int act, int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d, expected %0d (cyc %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(string tag);
        for (int k = 0; k < 2; k++) begin
            chk(obs_cnt[k] == mc[k], {tag, "_count"}, k, int'(obs_cnt[k]), mc[k]);
            chk(obs_max[k] == (mc[k] == MAXV), {tag, "_at_max"}, k, int'(obs_max[k]), int'(mc[k] == MAXV));
            chk(obs_min[k] == (mc[k] == MINV), {tag, "_at_min"}, k, int'(obs_min[k]), int'(mc[k] == MINV));
            chk(obs_busy[k] == 1'b0, {tag, "_busy"}, k, int'(obs_busy[k]), 0);
        end
    endtask

    task automatic do_reset();
        int t;
        t = cyc + 1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) push_ev(k, t, MINV, 1'b0);
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            chk(obs_cnt[k] == MINV, "rst_count", k, int'(obs_cnt[k]), MINV);
            chk(obs_min[k] == 1'b1 && obs_max[k] == 1'b0, "rst_limits", k, int'({obs_min[k], obs_max[k]}), 2);
            chk(obs_busy[k] == 1'b1, "rst_busy", k, int'(obs_busy[k]), 1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic load(int v);
        int t;
        t = cyc + 1;
        ld_s = 1'b1;
        ldv_s = W'(v);
        for (int k = 0; k < 2; k++) do_load(k, t + 1, v);
        tick();
        ld_s = 1'b0;
        repeat (3) tick();
        check_flags("load");
    endtask

    task automatic press(bit up, int h);
        int t;
        t = cyc + 1;
        for (int k = 0; k < 2; k++) model_press(k, up, t, h);
        if (up) u_s = 1'b1;
        else    d_s = 1'b1;
        repeat (h) tick();
        u_s = 1'b0;
        d_s = 1'b0;
        repeat (4) tick();
        check_flags(up ? "press_up" : "press_dn");
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mon_en && (int'(obs_cnt[k]) != prev_cnt[k] || obs_wr[k])) begin
                    checks++;
                    if (qsize(k) == 0) begin
                        errors++;
                        $display("FAIL unexpected_event inst%0d: count=%0d wrapped=%0b at cyc %0d, expected no change",
                                 k, obs_cnt[k], obs_wr[k], cyc);
                    end else begin
                        e = qpop(k);
                        if (e.cyc != cyc || e.cnt != int'(obs_cnt[k]) || e.wr != obs_wr[k]) begin
                            errors++;
                            $display("FAIL event inst%0d: got cyc=%0d count=%0d wrapped=%0b, expected cyc=%0d count=%0d wrapped=%0b",
                                     k, cyc, obs_cnt[k], obs_wr[k], e.cyc, e.cnt, e.wr);
                        end
                    end
                end
                prev_cnt[k] = int'(obs_cnt[k]);
            end
        end
    end

    initial begin
        int t;
        int r;
        cyc = 0; checks = 0; errors = 0; mon_en = 1'b0;
        rst = 1'b0; u_s = 1'b0; d_s = 1'b0; ld_s = 1'b0; ldv_s = '0;
        mc[0] = MINV; mc[1] = MINV;
        tick();
        do_reset();
        mon_en = 1'b1;
        tick();
        check_flags("after_reset");

        press(1'b1, 1);
        load(8);
        press(1'b1, 1);
        press(1'b1, 2);
        load(4);
        press(1'b0, 1);
        load(3);
        press(1'b0, 1);

        // Simultaneous U/D rise is ignored.
        u_s = 1'b1; d_s = 1'b1;
        tick();
        u_s = 1'b0; d_s = 1'b0;
        repeat (3) tick();
        check_flags("both");

        // Load wins over a U rise in the same cycle; the out-of-range value is clamped.
        t = cyc + 1;
        ld_s = 1'b1; ldv_s = 8'd255; u_s = 1'b1;
        for (int k = 0; k < 2; k++) do_load(k, t + 1, 255);
        tick();
        ld_s = 1'b0; u_s = 1'b0;
        repeat (3) tick();
        check_flags("ld_vs_u");
        load(0);

        load(2);
        press(1'b1, 40);
        press(1'b0, 23);

        // Load during HOLD aborts the repeat; the still-held U must not step again.
        load(3);
        t = cyc + 1;
        u_s = 1'b1;
        for (int k = 0; k < 2; k++) do_step(k, 1'b1, t + 1);
        repeat (3) tick();
        ld_s = 1'b1; ldv_s = 8'd7;
        for (int k = 0; k < 2; k++) do_load(k, t + 4, 7);
        tick();
        ld_s = 1'b0;
        repeat (25) tick();
        check_flags("ld_in_hold");
        u_s = 1'b0;
        repeat (4) tick();

        // Reset while U is held with a repeat pending; U must be re-pressed afterwards.
        load(5);
        t = cyc + 1;
        u_s = 1'b1;
        for (int k = 0; k < 2; k++) do_step(k, 1'b1, t + 1);
        repeat (3) tick();
        do_reset();
        repeat (25) tick();
        check_flags("rst_in_hold");
        u_s = 1'b0;
        repeat (4) tick();
        press(1'b1, 1);

        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 2));
            if (r == 0) load(int'($urandom_range(0, 255)));
            else        press(r == 1, int'($urandom_range(1, 45)));
        end

        repeat (5) tick();
        for (int k = 0; k < 2; k++) chk(qsize(k) == 0, "queue_drained", k, qsize(k), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
